// File: rtl/stopwatch_controller_if.sv
// Button pulses into the stopwatch and the registered display/status outputs.
// The master side drives the buttons; the slave side is the controller.
interface stopwatch_controller_if;
    logic        btn_start_stop;
    logic        btn_clear;
    logic        btn_set;
    logic        btn_inc;
    logic        btn_next;
    logic [15:0] number;
    logic        set_mode;
    logic [1:0]  digit_sel;
    logic        running;

    modport master (
        output btn_start_stop, btn_clear, btn_set, btn_inc, btn_next,
        input  number, set_mode, digit_sel, running
    );

    modport slave (
        input  btn_start_stop, btn_clear, btn_set, btn_inc, btn_next,
        output number, set_mode, digit_sel, running
    );
endinterface

// File: rtl/stopwatch_controller.sv
// Four-digit BCD stopwatch (SS.hh) with run/pause, clear and a per-digit set mode.
// All outputs are registered; the count saturates at 99.99 instead of wrapping.
module stopwatch_controller #(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_RATE_IN_HERTZ          = 100
) (
    input logic                   clk,
    input logic                   rst_n,
    stopwatch_controller_if.slave sw
);
    localparam int DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HERTZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [15:0]   NUM_MAX    = 16'h9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        SET   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   number_q, number_d;
    logic [1:0]    digit_sel_q, digit_sel_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          set_mode_q, running_q;
    logic          tick, at_max;

    assign tick   = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign at_max = (number_q == NUM_MAX);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            number_q    <= '0;
            digit_sel_q <= '0;
            presc_q     <= '0;
            set_mode_q  <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            number_q    <= number_d;
            digit_sel_q <= digit_sel_d;
            presc_q     <= presc_d;
            set_mode_q  <= (state_d == SET);
            running_q   <= (state_d == RUN);
        end
    end

    // Button priority is clear > set > start_stop; a saturating tick forces PAUSE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sw.btn_clear)           state_d = IDLE;
                else if (sw.btn_set)        state_d = SET;
                else if (sw.btn_start_stop) state_d = RUN;
            end
            RUN: begin
                if (sw.btn_clear)                              state_d = IDLE;
                else if ((tick && at_max) || sw.btn_start_stop) state_d = PAUSE;
            end
            PAUSE: begin
                if (sw.btn_clear)                          state_d = IDLE;
                else if (sw.btn_set)                       state_d = SET;
                else if (sw.btn_start_stop && !at_max)     state_d = RUN;
            end
            SET: begin
                if (sw.btn_clear)    state_d = IDLE;
                else if (sw.btn_set) state_d = PAUSE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler restarts from 0 on every entry to RUN, so the first tick is DIV cycles later.
    always_comb begin
        number_d    = number_q;
        digit_sel_d = digit_sel_q;
        presc_d     = '0;
        if (state_q == RUN && state_d == RUN && !tick)
            presc_d = presc_q + 1'b1;
        case (state_q)
            IDLE: begin
                number_d = '0;
                if (!sw.btn_clear && sw.btn_set) digit_sel_d = 2'd0;
            end
            RUN: begin
                if (sw.btn_clear)           number_d = '0;
                else if (tick && !at_max)   number_d = bcd_inc(number_q);
            end
            PAUSE: begin
                if (sw.btn_clear)    number_d    = '0;
                else if (sw.btn_set) digit_sel_d = 2'd0;
            end
            SET: begin
                if (sw.btn_clear) begin
                    number_d    = '0;
                    digit_sel_d = 2'd0;
                end else if (!sw.btn_set) begin
                    if (sw.btn_inc)
                        number_d[{digit_sel_q, 2'b00} +: 4] =
                            digit_inc(number_q[{digit_sel_q, 2'b00} +: 4]);
                    if (sw.btn_next)
                        digit_sel_d = digit_sel_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign sw.number    = number_q;
    assign sw.set_mode  = set_mode_q;
    assign sw.digit_sel = digit_sel_q;
    assign sw.running   = running_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller: directed scenarios plus a random
// button stream compared against a decimal-valued behavioural model.
module tb_stopwatch_controller;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_CLR  = 5'b10000;
    localparam logic [4:0] B_SET  = 5'b01000;
    localparam logic [4:0] B_SS   = 5'b00100;
    localparam logic [4:0] B_INC  = 5'b00010;
    localparam logic [4:0] B_NXT  = 5'b00001;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_SET   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Model: elapsed time as a plain integer of hundredths, edited digit as an index.
    int m_state, m_val, m_sel, m_run_start, cyc;

    stopwatch_controller_if sw_if();

    stopwatch_controller #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(CLK_HZ),
        .TICK_RATE_IN_HERTZ(TICK_HZ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation ran past its time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_val = 0; m_sel = 0; m_run_start = 0;
    endtask

    task automatic model_step(input logic [4:0] b);
        bit clr, set, ss, inc, nxt, tick;
        int p, d;
        {clr, set, ss, inc, nxt} = b;
        cyc++;
        tick = (m_state == M_RUN) && ((cyc - m_run_start) % DIV == 0);
        case (m_state)
            M_IDLE: begin
                if (clr) ;
                else if (set) begin m_state = M_SET; m_sel = 0; end
                else if (ss) begin m_state = M_RUN; m_run_start = cyc; end
            end
            M_RUN: begin
                if (clr) begin m_state = M_IDLE; m_val = 0; end
                else begin
                    if (tick) begin
                        if (m_val == 9999) m_state = M_PAUSE;
                        else m_val = m_val + 1;
                    end
                    if (ss) m_state = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (clr) begin m_state = M_IDLE; m_val = 0; end
                else if (set) begin m_state = M_SET; m_sel = 0; end
                else if (ss && m_val != 9999) begin m_state = M_RUN; m_run_start = cyc; end
            end
            default: begin
                if (clr) begin m_state = M_IDLE; m_val = 0; m_sel = 0; end
                else if (set) m_state = M_PAUSE;
                else begin
                    if (inc) begin
                        p = 1;
                        for (int k = 0; k < m_sel; k++) p = p * 10;
                        d = (m_val / p) % 10;
                        m_val = m_val - d * p + ((d + 1) % 10) * p;
                    end
                    if (nxt) m_sel = (m_sel + 1) % 4;
                end
            end
        endcase
    endtask

    // Buttons change at the falling edge and stay for exactly one rising edge.
    task automatic step(input logic [4:0] b);
        {sw_if.btn_clear, sw_if.btn_set, sw_if.btn_start_stop, sw_if.btn_inc, sw_if.btn_next} = b;
        @(posedge clk);
        model_step(b);
        @(negedge clk);
        {sw_if.btn_clear, sw_if.btn_set, sw_if.btn_start_stop, sw_if.btn_inc, sw_if.btn_next} = B_NONE;
    endtask

    task automatic idle(input int n);
        repeat (n) step(B_NONE);
    endtask

    task automatic test_reset();
        {sw_if.btn_clear, sw_if.btn_set, sw_if.btn_start_stop, sw_if.btn_inc, sw_if.btn_next} = B_NONE;
        cyc = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (sw_if.number !== 16'h0000) begin errors++; $display("[TB] FAIL reset_number got=%h exp=0000", sw_if.number); end
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got=%b exp=0", sw_if.running); end
        checks++; if (sw_if.set_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_set_mode got=%b exp=0", sw_if.set_mode); end
        checks++; if (sw_if.digit_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_digit_sel got=%0d exp=0", sw_if.digit_sel); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_counting();
        logic [15:0] prev;
        int first;
        first = -1;
        step(B_SS);
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("[TB] FAIL count_run_entry got=%b exp=1", sw_if.running); end
        for (int i = 1; i <= 100; i++) begin
            prev = sw_if.number;
            step(B_NONE);
            if (first < 0 && sw_if.number !== prev) first = i;
        end
        checks++; if (first != DIV) begin errors++; $display("[TB] FAIL count_first_change got=%0d exp=%0d", first, DIV); end
        checks++; if (sw_if.number !== 16'h0010) begin errors++; $display("[TB] FAIL count_100 got=%h exp=0010", sw_if.number); end
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("[TB] FAIL count_running got=%b exp=1", sw_if.running); end
        step(B_CLR);
        checks++; if (sw_if.number !== 16'h0000 || sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL count_clear got=%h/%b exp=0000/0", sw_if.number, sw_if.running); end
    endtask

    task automatic test_editing();
        step(B_SET);
        checks++; if (sw_if.set_mode !== 1'b1 || sw_if.digit_sel !== 2'd0) begin errors++; $display("[TB] FAIL edit_enter got=%b/%0d exp=1/0", sw_if.set_mode, sw_if.digit_sel); end
        repeat (3) step(B_INC);
        step(B_NXT);
        checks++; if (sw_if.number !== 16'h0003 || sw_if.digit_sel !== 2'd1) begin errors++; $display("[TB] FAIL edit_d0 got=%h/%0d exp=0003/1", sw_if.number, sw_if.digit_sel); end
        repeat (12) step(B_INC);
        step(B_SET);
        checks++; if (sw_if.number !== 16'h0023) begin errors++; $display("[TB] FAIL edit_value got=%h exp=0023", sw_if.number); end
        checks++; if (sw_if.set_mode !== 1'b0 || sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL edit_exit got=%b/%b exp=0/0", sw_if.set_mode, sw_if.running); end
        checks++; if (sw_if.digit_sel !== 2'd1) begin errors++; $display("[TB] FAIL edit_sel_hold got=%0d exp=1", sw_if.digit_sel); end
        idle(20);
        checks++; if (sw_if.number !== 16'h0023) begin errors++; $display("[TB] FAIL edit_pause_hold got=%h exp=0023", sw_if.number); end
        step(B_SET);
        repeat (2) step(B_NXT);
        step(B_INC | B_NXT);
        checks++; if (sw_if.number !== 16'h0123 || sw_if.digit_sel !== 2'd3) begin errors++; $display("[TB] FAIL edit_inc_next got=%h/%0d exp=0123/3", sw_if.number, sw_if.digit_sel); end
        step(B_NXT);
        checks++; if (sw_if.digit_sel !== 2'd0) begin errors++; $display("[TB] FAIL edit_sel_wrap got=%0d exp=0", sw_if.digit_sel); end
        step(B_CLR);
        checks++; if (sw_if.number !== 16'h0000 || sw_if.set_mode !== 1'b0) begin errors++; $display("[TB] FAIL edit_clear got=%h/%b exp=0000/0", sw_if.number, sw_if.set_mode); end
    endtask

    task automatic test_saturation();
        step(B_SET);
        repeat (8) step(B_INC);
        for (int k = 0; k < 3; k++) begin
            step(B_NXT);
            repeat (9) step(B_INC);
        end
        step(B_SET);
        checks++; if (sw_if.number !== 16'h9998) begin errors++; $display("[TB] FAIL sat_preload got=%h exp=9998", sw_if.number); end
        step(B_SS);
        idle(DIV);
        checks++; if (sw_if.number !== 16'h9999 || sw_if.running !== 1'b1) begin errors++; $display("[TB] FAIL sat_tick1 got=%h/%b exp=9999/1", sw_if.number, sw_if.running); end
        idle(DIV);
        checks++; if (sw_if.number !== 16'h9999 || sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL sat_tick2 got=%h/%b exp=9999/0", sw_if.number, sw_if.running); end
        step(B_SS);
        idle(15);
        checks++; if (sw_if.number !== 16'h9999 || sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL sat_restart got=%h/%b exp=9999/0", sw_if.number, sw_if.running); end
        step(B_CLR);
    endtask

    task automatic test_priority();
        step(B_SS);
        idle(15);
        checks++; if (sw_if.number !== 16'h0001) begin errors++; $display("[TB] FAIL prio_pre got=%h exp=0001", sw_if.number); end
        step(B_CLR | B_SET | B_SS);
        checks++; if (sw_if.number !== 16'h0000 || sw_if.running !== 1'b0 || sw_if.set_mode !== 1'b0) begin errors++; $display("[TB] FAIL prio_clear got=%h/%b/%b exp=0000/0/0", sw_if.number, sw_if.running, sw_if.set_mode); end
        idle(12);
        checks++; if (sw_if.number !== 16'h0000 || sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle got=%h/%b exp=0000/0", sw_if.number, sw_if.running); end
    endtask

    task automatic test_carry();
        step(B_SET);
        repeat (9) step(B_INC);
        for (int k = 0; k < 2; k++) begin
            step(B_NXT);
            repeat (9) step(B_INC);
        end
        step(B_SET);
        checks++; if (sw_if.number !== 16'h0999) begin errors++; $display("[TB] FAIL carry_preload got=%h exp=0999", sw_if.number); end
        step(B_SS);
        idle(DIV - 1);
        checks++; if (sw_if.number !== 16'h0999) begin errors++; $display("[TB] FAIL carry_early got=%h exp=0999", sw_if.number); end
        idle(1);
        checks++; if (sw_if.number !== 16'h1000) begin errors++; $display("[TB] FAIL carry_tick got=%h exp=1000", sw_if.number); end
        step(B_CLR);
    endtask

    task automatic test_async_reset();
        step(B_SS);
        idle(25);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (sw_if.number !== 16'h0000 || sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL areset_run got=%h/%b exp=0000/0", sw_if.number, sw_if.running); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(50);
        checks++; if (sw_if.number !== 16'h0000 || sw_if.running !== 1'b0) begin errors++; $display("[TB] FAIL areset_wait got=%h/%b exp=0000/0", sw_if.number, sw_if.running); end
        step(B_SET);
        step(B_NXT);
        step(B_INC);
        checks++; if (sw_if.set_mode !== 1'b1 || sw_if.number !== 16'h0010) begin errors++; $display("[TB] FAIL areset_preset got=%b/%h exp=1/0010", sw_if.set_mode, sw_if.number); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (sw_if.set_mode !== 1'b0 || sw_if.digit_sel !== 2'd0 || sw_if.number !== 16'h0000) begin errors++; $display("[TB] FAIL areset_set got=%b/%0d/%h exp=0/0/0000", sw_if.set_mode, sw_if.digit_sel, sw_if.number); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_random();
        int r;
        logic [4:0] b;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       b = B_CLR;
            else if (r < 6)  b = B_SET;
            else if (r < 12) b = B_SS;
            else if (r < 24) b = B_INC;
            else if (r < 30) b = B_NXT;
            else if (r < 33) b = B_INC | B_NXT;
            else             b = B_NONE;
            step(b);
            checks++; if (sw_if.number !== to_bcd(m_val)) begin errors++; $display("[TB] FAIL rand_number step=%0d got=%h exp=%h", i, sw_if.number, to_bcd(m_val)); end
            checks++; if (sw_if.running !== (m_state == M_RUN)) begin errors++; $display("[TB] FAIL rand_running step=%0d got=%b exp=%b", i, sw_if.running, m_state == M_RUN); end
            checks++; if (sw_if.set_mode !== (m_state == M_SET)) begin errors++; $display("[TB] FAIL rand_set_mode step=%0d got=%b exp=%b", i, sw_if.set_mode, m_state == M_SET); end
            checks++; if (sw_if.digit_sel !== 2'(m_sel)) begin errors++; $display("[TB] FAIL rand_digit_sel step=%0d got=%0d exp=%0d", i, sw_if.digit_sel, m_sel); end
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_editing();
        test_saturation();
        test_priority();
        test_carry();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 SHALL have parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000, the clk frequency.
REQ-002 SHALL have parameter TICK_RATE_IN_HERTZ, default 100, the count rate (hundredths of a second).
REQ-003 SHALL have input clk, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have input rst_n, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have input btn_start_stop, 1 bit: one-cycle pulse, debounced upstream.
REQ-006 SHALL have input btn_clear, 1 bit: one-cycle pulse.
REQ-007 SHALL have input btn_set, 1 bit: one-cycle pulse, enter/leave set mode.
REQ-008 SHALL have input btn_inc, 1 bit: one-cycle pulse, increment the edited digit.
REQ-009 SHALL have input btn_next, 1 bit: one-cycle pulse, advance the edited digit.
REQ-010 SHALL have output number, 16 bits: four BCD digits {d3,d2,d1,d0} = SS.hh, d0 in [3:0]; feeds the 4-digit display.
REQ-011 SHALL have output set_mode, 1 bit: high in SET; drives the display blink.
REQ-012 SHALL have output digit_sel, 2 bits: index of the digit being edited.
REQ-013 SHALL have output running, 1 bit: high in RUN.

Function
REQ-014 SHALL run an internal prescaler with DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HERTZ; DIV >= 2 is a legal-configuration requirement.
REQ-015 SHALL assert the internal tick for one cycle when the prescaler reaches DIV-1, then wrap it to 0.
REQ-016 SHALL count the prescaler only in RUN, and clear it to 0 on every transition into RUN, so the first increment lands exactly DIV cycles after entry.
REQ-017 SHALL implement states IDLE, RUN, PAUSE, SET, encoded as 2 bits.
REQ-018 SHALL apply button priority btn_clear > btn_set > btn_start_stop when several are asserted in one cycle; btn_inc and btn_next act only in SET.
REQ-019 IDLE: number = 0; start_stop -> RUN; set -> SET with digit_sel = 0.
REQ-020 RUN: each tick increments number as a BCD counter (d0 wraps 9->0 with carry into d1, up to d3); start_stop -> PAUSE; clear -> IDLE with number = 0; set ignored.
REQ-021 RUN saturation: a tick while number = 9999 holds 9999 and moves the state to PAUSE; the counter never wraps to 0000.
REQ-022 If a tick and start_stop occur in the same cycle, the increment SHALL still be applied and the state SHALL go to PAUSE.
REQ-023 PAUSE: number holds; start_stop -> RUN, unless number = 9999, in which case it stays in PAUSE; set -> SET with digit_sel = 0; clear -> IDLE with number = 0.
REQ-024 SET, btn_inc: the selected digit SHALL increment modulo 10 with no carry, and other digits SHALL be unchanged.
REQ-025 SET, btn_next: digit_sel SHALL increment modulo 4 (3 -> 0).
REQ-026 SET, inc and next asserted in the same cycle: inc SHALL apply to the old digit_sel and digit_sel SHALL then advance.
REQ-027 SET, set -> PAUSE with the edited value retained; start_stop ignored; clear -> IDLE with number = 0 and digit_sel = 0.
REQ-028 SHALL register all outputs, so each output reflects the state transition one cycle after the causing pulse.
REQ-029 SHALL hold digit_sel at its last value outside SET, and set it to 0 on every entry to SET.

Reset
REQ-030 SHALL, while rst_n = 0, immediately force state = IDLE, number = 0, digit_sel = 0, prescaler = 0, set_mode = 0 and running = 0, regardless of clk.
REQ-031 SHALL, when rst_n is asserted mid-RUN or mid-SET, discard all progress; after release the block SHALL wait in IDLE for a button.

Verification (BOARD_CLOCK_FREQUENCY_IN_HZ = 1000, TICK_RATE_IN_HERTZ = 100, DIV = 10)
REQ-032 Bench SHALL check counting: start_stop pulse, then 100 cycles -> number = 0x0010, running = 1; first change exactly 10 cycles after the state becomes RUN.
REQ-033 Bench SHALL check saturation: set the value to 9998 via SET, exit, start -> after 2 ticks number = 0x9999, state PAUSE, running = 0; a further start_stop leaves it in PAUSE.
REQ-034 Bench SHALL check editing: from IDLE, set, inc x3, next, inc x12, set -> number = 0x0023, set_mode 1 -> 0, state PAUSE.
REQ-035 Bench SHALL check priority: clear, set and start_stop in the same cycle during RUN -> IDLE, number = 0.
REQ-036 Bench SHALL check the carry chain: preload 0x0999 via SET, run one tick -> 0x1000.
REQ-037 Bench SHALL check asynchronous reset: rst_n low mid-RUN, between clock edges -> outputs zero before the next edge; after release, 50 cycles with no buttons -> number still 0.
